// File: rtl/vga_timing_pkg.sv
// Shared timing constants, widths and the coordinate type for the VGA raster generator.
package vga_timing_pkg;

  localparam int CNT_W   = 11;
  localparam int COORD_W = 10;

  localparam int   DEF_H_SYNC   = 96;
  localparam int   DEF_H_BACK   = 48;
  localparam int   DEF_H_ACTIVE = 640;
  localparam int   DEF_H_FRONT  = 16;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BACK   = 33;
  localparam int   DEF_V_ACTIVE = 480;
  localparam int   DEF_V_FRONT  = 10;
  localparam logic DEF_SYNC_POL = 1'b0;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  function automatic int h_total(input int sync, input int back, input int active, input int front);
    return sync + back + active + front;
  endfunction

  function automatic int v_total(input int sync, input int back, input int active, input int front);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it (master), the pixel stage consumes it (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               pix_req;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               de;
  logic               frame_start;

  modport master (output hsync, vsync, pix_req, pix_x, pix_y, de, frame_start);
  modport slave  (input  hsync, vsync, pix_req, pix_x, pix_y, de, frame_start);
endinterface

// File: rtl/vga_pix_ce.sv
// Divide-by-2 pixel clock enable; only built when VGA_TIMING_CLKDIV_EN is defined.
`ifdef VGA_TIMING_CLKDIV_EN
module vga_pix_ce (
  input  logic clk,
  input  logic rst_n,
  output logic pix_ce_o
);

  logic phase_q;
  logic phase_d;

  assign phase_d  = ~phase_q;
  // Enable on phase 1 so the first pixel tick lands on the second edge after release.
  assign pix_ce_o = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 1'b0;
    else        phase_q <= phase_d;
  end

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// VGA raster counters and registered sync/request/enable decode.
// VGA_TIMING_CLKDIV_EN: pixel tick = clk/2 via vga_pix_ce; otherwise every clk edge is a tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  // Request window runs one tick early so the downstream register lines up with de.
  localparam logic [CNT_W-1:0] H_REQ_LO  = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_REQ_HI  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_VIS_LO  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_VIS_HI  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic             pix_ce;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pix_req_q, pix_req_d;
  logic             de_q;
  logic             frame_start_q, frame_start_d;
  coord_t           coord_q, coord_d;

`ifdef VGA_TIMING_CLKDIV_EN
  vga_pix_ce u_pix_ce (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce_o (pix_ce)
  );
`else
  assign pix_ce = 1'b1;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_d       = (h_cnt_q < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_cnt_q < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    pix_req_d     = (h_cnt_q >= H_REQ_LO) && (h_cnt_q < H_REQ_HI) &&
                    (v_cnt_q >= V_VIS_LO) && (v_cnt_q < V_VIS_HI);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    coord_d       = '0;
    if (pix_req_d) begin
      coord_d.x = COORD_W'(h_cnt_q - H_REQ_LO);
      coord_d.y = COORD_W'(v_cnt_q - V_VIS_LO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      pix_req_q     <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      coord_q       <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (pix_ce) begin
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        pix_req_q     <= pix_req_d;
        de_q          <= pix_req_q;
        frame_start_q <= frame_start_d;
        coord_q       <= coord_d;
      end
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.pix_req     = pix_req_q;
  assign vif.pix_x       = coord_q.x;
  assign vif.pix_y       = coord_q.y;
  assign vif.de          = de_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized checker for vga_timing_gen against a tick-index raster model, with frame statistics.
module tb_vga_timing_gen;

  localparam int   HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int   VS = 2, VB = 2, VA = 5,  VF = 1;
  localparam int   HT = HS + HB + HA + HF;
  localparam int   VT = VS + VB + VA + VF;
  localparam int   FRAME = HT * VT;
  localparam logic POL = 1'b0;
`ifdef VGA_TIMING_CLKDIV_EN
  localparam int   DIV = 2;
`else
  localparam int   DIV = 1;
`endif
  localparam logic [24:0] RST_VEC = {~POL, ~POL, 23'd0};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   edge_cnt;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(POL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Outputs registered after pixel tick t (t counted from 0 after reset release).
  function automatic logic [24:0] decode(input int t);
    int pos, line, col;
    logic hs, vs, rq;
    logic [9:0] x, y;
    pos  = t % FRAME;
    line = pos / HT;
    col  = pos % HT;
    hs   = (col < HS) ? POL : ~POL;
    vs   = (line < VS) ? POL : ~POL;
    rq   = (line >= VS + VB) && (line < VS + VB + VA) &&
           (col >= HS + HB - 1) && (col < HS + HB + HA - 1);
    x    = rq ? 10'(col + 1 - HS - HB) : 10'd0;
    y    = rq ? 10'(line - VS - VB) : 10'd0;
    return {hs, vs, rq, x, y, 1'b0, (pos == 0)};
  endfunction

  function automatic logic [24:0] expected(input int e);
    int n;
    logic [24:0] cur, prev;
    n = e / DIV;
    if (n == 0) return RST_VEC;
    cur = decode(n - 1);
    if (n >= 2) begin
      prev   = decode(n - 2);
      cur[1] = prev[22];
    end
    return cur;
  endfunction

  function automatic logic [24:0] observed();
    return {vif.hsync, vif.vsync, vif.pix_req, vif.pix_x, vif.pix_y, vif.de, vif.frame_start};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    check_val("outs", 32'(observed()), 32'(expected(edge_cnt)));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", 32'(observed()), 32'(RST_VEC));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_hold", 32'(observed()), 32'(RST_VEC));
    end
    @(negedge clk);
    #2;
    rst_n    = 1'b1;
    edge_cnt = 0;
    $display("reset pulse: hold %0d clk, restart", hold);
  endtask

  task automatic measure_frame();
    int   guard, clks, de_clks, de_lines, hs_pulses, vs_clks;
    logic prev_fs, prev_de, prev_hs;
    guard = 0;
    do begin
      prev_fs = vif.frame_start;
      step();
      guard++;
    end while (!(vif.frame_start && !prev_fs) && guard < 2 * FRAME * DIV + 8);
    if (!(vif.frame_start && !prev_fs)) begin
      check_val("fs_found", 32'(guard), 32'(0));
      return;
    end
    clks = 0; de_clks = 0; de_lines = 0; hs_pulses = 0; vs_clks = 0;
    do begin
      prev_fs = vif.frame_start;
      prev_de = vif.de;
      prev_hs = vif.hsync;
      step();
      clks++;
      if (vif.de) de_clks++;
      if (vif.de && !prev_de) de_lines++;
      if (vif.hsync == POL && prev_hs != POL) hs_pulses++;
      if (vif.vsync == POL) vs_clks++;
    end while (!(vif.frame_start && !prev_fs) && clks < 2 * FRAME * DIV + 8);
    check_val("frame_period", 32'(clks), 32'(FRAME * DIV));
    check_val("de_ticks", 32'(de_clks), 32'(HA * VA * DIV));
    check_val("de_lines", 32'(de_lines), 32'(VA));
    check_val("hsync_pulses", 32'(hs_pulses), 32'(VT));
    check_val("vsync_width", 32'(vs_clks), 32'(VS * HT * DIV));
    $display("frame measured: %0d clk, %0d de clk, %0d lines, %0d hsync", clks, de_clks, de_lines, hs_pulses);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    edge_cnt = 0;
    rst_n    = 1'b0;
    #12;
    check_val("por_rst", 32'(observed()), 32'(RST_VEC));
    #2;
    rst_n = 1'b1;
    $display("power-on reset released");

    run_cycles(FRAME * DIV / 2 + int'($urandom_range(0, 40)));
    measure_frame();

    for (int k = 0; k < 5; k++) begin
      async_reset(int'($urandom_range(0, 3)));
      run_cycles(int'($urandom_range(1, FRAME * DIV * 3 / 2)));
    end

    async_reset(1);
    measure_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA display path. It produces hsync/vsync, the active-video qualifier and pixel coordinates for the pixel-drawing stage directly downstream, which registers its colour output one pixel tick after receiving a coordinate. Default timing is 640x480@60 (800x525 total). The pixel tick is derived from the 50 MHz system clock.

## Interface
- H_SYNC, 96, hsync pulse width in pixel ticks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- SYNC_POL, 1'b0, active level of hsync/vsync

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- hsync  out  1  horizontal sync, SYNC_POL when asserted
- vsync  out  1  vertical sync, SYNC_POL when asserted
- pix_req  out  1  coordinate request, one pixel tick ahead of de
- pix_x  out  10  column of requested pixel, 0..H_ACTIVE-1; 0 when pix_req=0
- pix_y  out  10  row of requested pixel, 0..V_ACTIVE-1; 0 when pix_req=0
- de  out  1  display enable, aligned with downstream registered rgb
- frame_start  out  1  one-tick pulse at h_cnt=0, v_cnt=0

## Operation
- Internal h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), where H_TOTAL = sum of H_* and V_TOTAL = sum of V_*. Both advance only on pix_ce.
- Line order is sync, back porch, active, front porch. H_START = H_SYNC+H_BACK; V_START = V_SYNC+V_BACK.
- h_cnt wraps from H_TOTAL-1 to 0. v_cnt increments on the same tick. v_cnt wraps from V_TOTAL-1 to 0 on the H wrap of its last line.
- Decode, registered on pix_ce:
  - hsync = SYNC_POL while h_cnt < H_SYNC.
  - vsync = SYNC_POL while v_cnt < V_SYNC.
  - pix_req while v_cnt is in [V_START, V_START+V_ACTIVE) and h_cnt is in [H_START-1, H_START+H_ACTIVE-1).
  - pix_x = h_cnt+1-H_START and pix_y = v_cnt-V_START while pix_req is high.
  - de = pix_req delayed by one pixel tick.
- All arithmetic is on unsigned 11-bit counters. pix_x and pix_y are truncated to 10 bits, and the values are always in range.
- rst_n low, asynchronously: counters go to 0; hsync and vsync go to ~SYNC_POL; pix_req, de, pix_x, pix_y and frame_start go to 0; the divider phase goes to 0.
- Reset mid-frame: all state is abandoned. After release the block restarts at (0,0) with frame_start, and no partial line is completed.

## Timing
- Outputs are registered and change only on pix_ce edges. Each value holds for one pixel tick.
- First pix_ce after reset release decodes (0,0): frame_start=1, hsync=vsync=SYNC_POL.
- pix_req leads de by exactly 1 pixel tick. The pix_x/pix_y request issued with pix_req maps to the de tick that follows.
- hsync period is H_TOTAL ticks. vsync period is H_TOTAL*V_TOTAL ticks. The hsync edge and the vsync edge that start a line coincide.
- Per visible line: exactly H_ACTIVE de ticks. Per frame: exactly V_ACTIVE lines carrying de.

## Configuration
- Macro: VGA_TIMING_CLKDIV_EN.
- Defined: sub-module vga_pix_ce divides clk by 2. The 1-bit phase register resets to 0 and toggles every clk. pix_ce = (phase==1), so the first tick falls on the 2nd clk edge after release and each output holds 2 clk.
- Undefined: pix_ce is tied to 1 and every clk edge is a pixel tick. The clk input is then the pixel clock.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants (H_*/V_*), H_TOTAL/V_TOTAL functions;
  - counter width (11) and coordinate width (10) localparams;
  - typedef for the coordinate pair.
- Sub-module vga_pix_ce: clock-enable divider. It is instantiated only under VGA_TIMING_CLKDIV_EN.
- Counter and decode logic lives in vga_timing_gen.

## Test plan
- Reset: hold rst_n=0 for 14 ns with clk toggling -> all outputs at reset values (hsync=vsync=1, others 0). Assert rst_n=0 asynchronously mid-clock -> outputs clear without waiting for a clock edge.
- Line timing, macro defined: measure hsync -> low for 96 ticks = 192 clk, period 1600 clk; de high for 640 consecutive ticks starting at tick 145 of the line (h_cnt=144 registered).
- Frame timing: count hsync pulses between frame_start pulses -> 525; lines with de -> 480; vsync low for 2 lines; frame period 420000 ticks.
- Coordinates: on the first visible line, pix_x steps 0..639 while pix_req=1 and pix_y=0; de rises exactly one tick after pix_req; pix_x=0 whenever pix_req=0. On the last visible line, pix_y=479.
- Mid-frame reset: pulse rst_n low at v_cnt=200 -> after release, frame_start on the first pix_ce and the next frame_start exactly 420000 ticks later.
- Macro undefined: same checks with every clk a tick -> hsync period 800 clk, frame_start on the first clk edge after release.
